// File: rtl/circle_pkg.sv
// Shared constants, state/direction types and colour sequencing for the
// circle motion controller and its per-axis stepper.
package circle_pkg;

  localparam int H_DISPLAY = 640;
  localparam int V_DISPLAY = 480;
  localparam int RADIUS    = 100;

  // Clamp window keeps the whole circle inside the visible area.
  localparam logic [9:0] XMIN = 10'(RADIUS);
  localparam logic [9:0] XMAX = 10'(H_DISPLAY - 1 - RADIUS);
  localparam logic [9:0] YMIN = 10'(RADIUS);
  localparam logic [9:0] YMAX = 10'(V_DISPLAY - 1 - RADIUS);

  typedef enum logic [1:0] {WAIT_VS, CALC, COMMIT} state_e;
  typedef enum logic {DIR_POS, DIR_NEG} dir_e;

  localparam logic [1:0] COLOR_0 = 2'b00;
  localparam logic [1:0] COLOR_1 = 2'b01;
  localparam logic [1:0] COLOR_2 = 2'b10;
  localparam logic [1:0] COLOR_3 = 2'b11;

  function automatic logic [1:0] color_next(input logic [1:0] c);
    case (c)
      COLOR_0: return COLOR_1;
      COLOR_1: return COLOR_2;
      COLOR_2: return COLOR_3;
      default: return COLOR_0;
    endcase
  endfunction

endpackage

// File: rtl/axis_step.sv
// Combinational one-axis update: auto mode steps and reflects off the
// limits, manual mode steps by button and clamps.
module axis_step
  import circle_pkg::*;
(
  input  logic [9:0] pos,
  input  dir_e       dir,
  input  logic [9:0] min,
  input  logic [9:0] max,
  input  logic [9:0] step,
  input  logic       mode,
  input  logic       plus,
  input  logic       minus,
  output logic [9:0] npos,
  output dir_e       ndir,
  output logic       bounced
);

  // Wide enough that pos +/- step can never wrap.
  logic signed [11:0] w_step;
  logic signed [11:0] w_delta;
  logic signed [11:0] w_next;

  assign w_step = $signed({2'b00, step});

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_delta = '0;
    if (mode) begin
      if (plus && !minus)      w_delta = w_step;
      else if (minus && !plus) w_delta = -w_step;
    end else begin
      w_delta = (dir == DIR_POS) ? w_step : -w_step;
    end
    w_next  = $signed({2'b00, pos}) + w_delta;
    npos    = w_next[9:0];
    ndir    = dir;
    bounced = 1'b0;
    if (w_next > $signed({2'b00, max})) begin
      npos = max;
      if (!mode) begin
        ndir    = DIR_NEG;
        bounced = 1'b1;
      end
    end else if (w_next < $signed({2'b00, min})) begin
      npos = min;
      if (!mode) begin
        ndir    = DIR_POS;
        bounced = 1'b1;
      end
    end
  end

endmodule

// File: rtl/circle_motion_ctrl.sv
// Moves the circle centre once every FRAME_DIV frames, only during vertical
// retrace, either bouncing automatically or stepping by buttons.
module circle_motion_ctrl
  import circle_pkg::*;
#(
  parameter int STEP      = 4,
  parameter int FRAME_DIV = 1,
  parameter int X0        = 320,
  parameter int Y0        = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        run,
  input  logic        manual,
  input  logic [3:0]  btn,
  output logic [19:0] C,
  output logic [1:0]  color,
  output logic        upd
);

  logic       r_vsync_d;
  logic       w_vs_rise;
  state_e     r_state, w_next_state;
  logic [7:0] r_frame_cnt;
  logic       w_div_hit;

  logic [9:0] r_x, r_y, r_nx, r_ny, w_nx, w_ny;
  dir_e       r_dx, r_dy, r_ndx, r_ndy, w_ndx, w_ndy;
  logic       w_bx, w_by;
  logic [1:0] r_color, r_ncolor, w_ncolor;
  logic       r_upd;

  assign w_vs_rise = vsync & ~r_vsync_d;
  assign w_div_hit = (r_frame_cnt == 8'(FRAME_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= WAIT_VS;
      r_vsync_d <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_vsync_d <= vsync;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WAIT_VS: if (w_vs_rise && run && w_div_hit) w_next_state = CALC;
      CALC:    w_next_state = COMMIT;
      COMMIT:  w_next_state = WAIT_VS;
      default: w_next_state = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (r_state == WAIT_VS && w_vs_rise && run) begin
      r_frame_cnt <= w_div_hit ? 8'd0 : r_frame_cnt + 8'd1;
    end
  end

  // btn is {up, down, left, right}; screen y grows downward.
  axis_step u_axis_x (
    .pos(r_x), .dir(r_dx), .min(XMIN), .max(XMAX), .step(10'(STEP)),
    .mode(manual), .plus(btn[0]), .minus(btn[1]),
    .npos(w_nx), .ndir(w_ndx), .bounced(w_bx)
  );

  axis_step u_axis_y (
    .pos(r_y), .dir(r_dy), .min(YMIN), .max(YMAX), .step(10'(STEP)),
    .mode(manual), .plus(btn[2]), .minus(btn[3]),
    .npos(w_ny), .ndir(w_ndy), .bounced(w_by)
  );

  // A corner hit bounces both axes but still advances the colour once.
  assign w_ncolor = (w_bx | w_by) ? color_next(r_color) : r_color;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x      <= 10'(X0);
      r_y      <= 10'(Y0);
      r_dx     <= DIR_POS;
      r_dy     <= DIR_POS;
      r_color  <= COLOR_0;
      r_nx     <= 10'(X0);
      r_ny     <= 10'(Y0);
      r_ndx    <= DIR_POS;
      r_ndy    <= DIR_POS;
      r_ncolor <= COLOR_0;
      r_upd    <= 1'b0;
    end else begin
      r_upd <= (r_state == COMMIT);
      if (r_state == CALC) begin
        r_nx     <= w_nx;
        r_ny     <= w_ny;
        r_ndx    <= w_ndx;
        r_ndy    <= w_ndy;
        r_ncolor <= w_ncolor;
      end
      if (r_state == COMMIT) begin
        r_x     <= r_nx;
        r_y     <= r_ny;
        r_dx    <= r_ndx;
        r_dy    <= r_ndy;
        r_color <= r_ncolor;
      end
    end
  end

  assign C     = {r_y, r_x};
  assign color = r_color;
  assign upd   = r_upd;

endmodule

// File: tb/tb_circle_motion_ctrl.sv
// Self-checking bench: two controllers (frame divider 1 and 3) driven by the
// same inputs and compared against an arithmetic model of the motion rules.
module tb_circle_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset, vsync, run, manual;
  logic [3:0]  btn;
  logic [19:0] c1, c3;
  logic [1:0]  col1, col3;
  logic        upd1, upd3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  circle_motion_ctrl #(.STEP(4), .FRAME_DIV(1), .X0(320), .Y0(240)) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .run(run), .manual(manual),
    .btn(btn), .C(c1), .color(col1), .upd(upd1)
  );

  circle_motion_ctrl #(.STEP(4), .FRAME_DIV(3), .X0(320), .Y0(240)) dut3 (
    .clk(clk), .reset(reset), .vsync(vsync), .run(run), .manual(manual),
    .btn(btn), .C(c3), .color(col3), .upd(upd3)
  );

  // Reference model: index 0 tracks dut, index 1 tracks dut3.
  localparam int LO_X = 100, HI_X = 539, LO_Y = 100, HI_Y = 379, STEP_M = 4;
  int mx[2], my[2], mdx[2], mdy[2], mcol[2], mfc[2];
  int div_m[2] = '{1, 3};
  bit mupd[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mx[k] = 320; my[k] = 240; mdx[k] = 1; mdy[k] = 1; mcol[k] = 0; mfc[k] = 0;
    end
  endtask

  task automatic auto_axis(inout int p, inout int d, input int lo, input int hi, output bit b);
    int n;
    n = p + STEP_M * d;
    b = 1'b0;
    if (n > hi)      begin p = hi; d = -1; b = 1'b1; end
    else if (n < lo) begin p = lo; d = 1;  b = 1'b1; end
    else p = n;
  endtask

  task automatic model_step(input int k);
    bit bx, by;
    int mvx, mvy;
    if (manual) begin
      mvx = (btn[0] && !btn[1]) ? STEP_M : (btn[1] && !btn[0]) ? -STEP_M : 0;
      mvy = (btn[2] && !btn[3]) ? STEP_M : (btn[3] && !btn[2]) ? -STEP_M : 0;
      mx[k] = clampi(mx[k] + mvx, LO_X, HI_X);
      my[k] = clampi(my[k] + mvy, LO_Y, HI_Y);
    end else begin
      auto_axis(mx[k], mdx[k], LO_X, HI_X, bx);
      auto_axis(my[k], mdy[k], LO_Y, HI_Y, by);
      if (bx || by) mcol[k] = (mcol[k] + 1) % 4;
    end
  endtask

  task automatic model_frame();
    for (int k = 0; k < 2; k++) begin
      mupd[k] = 1'b0;
      if (run) begin
        mfc[k]++;
        if (mfc[k] == div_m[k]) begin
          mfc[k] = 0;
          mupd[k] = 1'b1;
          model_step(k);
        end
      end
    end
  endtask

  function automatic logic [19:0] exp_c(input int k);
    return 20'(my[k] * 1024 + mx[k]);
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_c1"},   c1,   exp_c(0));
    check({tag, "_col1"}, col1, mcol[0]);
    check({tag, "_c3"},   c3,   exp_c(1));
    check({tag, "_col3"}, col3, mcol[1]);
  endtask

  // One vsync pulse held high for hi cycles; counts upd pulses meanwhile.
  task automatic frame(input int hi, input string tag);
    int u1, u3;
    u1 = 0; u3 = 0;
    @(negedge clk); vsync = 1'b1;
    for (int i = 0; i < hi + 6; i++) begin
      @(negedge clk);
      if (i == hi - 1) vsync = 1'b0;
      u1 += int'(upd1);
      u3 += int'(upd3);
    end
    model_frame();
    check_all(tag);
    check({tag, "_upd1"}, u1, mupd[0]);
    check({tag, "_upd3"}, u3, mupd[1]);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int colb, u;
    reset = 1'b1; vsync = 1'b0; run = 1'b0; manual = 1'b0; btn = 4'b0000;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_c1", c1, 20'h3C140);
    check("rst_col1", col1, 2'b00);
    check("rst_upd1", upd1, 1'b0);
    check("rst_c3", c3, 20'h3C140);

    // First update: C must move exactly on the second edge after the rise cycle.
    reset = 1'b0; run = 1'b1;
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); check("lat_calc_c", c1, 20'h3C140);
    @(negedge clk); check("lat_commit_c", c1, 20'h3C140);
    check("lat_commit_upd", upd1, 1'b0);
    @(negedge clk); check("lat_new_c", c1, 20'h3D144);
    check("lat_new_upd", upd1, 1'b1);
    vsync = 1'b0;
    @(negedge clk); check("lat_upd_drop", upd1, 1'b0);
    repeat (3) @(negedge clk);
    model_frame();
    check_all("first");

    // Drive toward the right wall, then bounce off it.
    for (int i = 0; i < 100 && mx[0] != 536; i++) frame(1, "to_wall");
    colb = mcol[0];
    frame(1, "wall");
    check("wall_x", c1[9:0], 539);
    check("wall_col", col1, (colb + 1) % 4);
    frame(1, "wall_back");
    check("wall_back_x", c1[9:0], 535);
    check("wall_back_col", col1, (colb + 1) % 4);

    // Line up both axes to hit the bottom-right corner together.
    do_reset();
    manual = 1'b1; btn = 4'b1000;
    repeat (20) frame(1, "man_up");
    check("man_up_c", c1, {10'd160, 10'd320});
    manual = 1'b0; btn = 4'b0000;
    repeat (54) frame(1, "to_corner");
    check("pre_corner_x", c1[9:0], 536);
    frame(1, "corner");
    check("corner_c", c1, {10'd379, 10'd539});
    check("corner_col", col1, 2'b01);

    // Reset during COMMIT discards the pending update.
    @(negedge clk); vsync = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    check("rcommit_c1", c1, 20'h3C140);
    check("rcommit_col1", col1, 2'b00);
    check("rcommit_c3", c3, 20'h3C140);
    @(negedge clk); reset = 1'b0; vsync = 1'b0;
    u = 0;
    repeat (5) begin @(negedge clk); u += int'(upd1); end
    check("rcommit_no_upd", u, 0);
    check("rcommit_c_hold", c1, 20'h3C140);
    model_reset();

    // Manual stepping, cancelling buttons and clamping at the left limit.
    manual = 1'b1; btn = 4'b0001;
    frame(1, "man_right");
    check("man_right_x", c1[9:0], 324);
    check("man_right_col", col1, 2'b00);
    btn = 4'b0011;
    frame(1, "man_cancel");
    check("man_cancel_x", c1[9:0], 324);
    btn = 4'b0010;
    repeat (60) frame(1, "man_left");
    check("man_left_c", c1, {10'd240, 10'd100});

    // Divider and pause: dut3 advances only on every third enabled rise.
    do_reset();
    manual = 1'b0; btn = 4'b0000; run = 1'b1;
    frame(1, "div_1");
    run = 1'b0;
    repeat (5) frame(1, "pause");
    run = 1'b1;
    frame(1, "div_2");
    check("div_2_c3", c3, 20'h3C140);
    frame(1, "div_3");
    check("div_3_c3", c3, 20'h3D144);

    // vsync held high yields a single update.
    frame(40, "stuck_hi");

    repeat (80) begin
      run    = ($urandom_range(0, 4) != 0);
      manual = 1'($urandom_range(0, 1));
      btn    = 4'($urandom);
      frame(int'($urandom_range(1, 12)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
